// File: rtl/noc_input_buffer_if.sv
// noc_input_buffer_if: link/arbiter-side signal bundle for the router input buffer
interface noc_input_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  logic [DATA_WIDTH-1:0]    ib_flit_i;
  logic                     ib_valid_i;
  logic                     ib_read_i;
  logic [DATA_WIDTH-1:0]    ib_flit_o;
  logic                     ib_empty_o;
  logic [15:0]              ib_addr_header_o;
  logic                     ib_header_o;
  logic                     ib_credit_o;
  logic [$clog2(DEPTH):0]   ib_count_o;
  logic                     ib_overflow_o;
  logic                     ib_underflow_o;
  modport master (
    output ib_flit_i, ib_valid_i, ib_read_i,
    input  ib_flit_o, ib_empty_o, ib_addr_header_o, ib_header_o,
           ib_credit_o, ib_count_o, ib_overflow_o, ib_underflow_o
  );
  modport slave (
    input  ib_flit_i, ib_valid_i, ib_read_i,
    output ib_flit_o, ib_empty_o, ib_addr_header_o, ib_header_o,
           ib_credit_o, ib_count_o, ib_overflow_o, ib_underflow_o
  );
endinterface

// File: rtl/noc_input_buffer.sv
// noc_input_buffer: FWFT flit FIFO with credit return and packet header tracking
module noc_input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PKT_LEN    = 4
) (
  input  logic                clk,
  input  logic                reset,
  noc_input_buffer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PKT_LEN);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [PW-1:0]         pkt_cnt;
  logic [15:0]           addr_q;
  logic                  credit, overflow, underflow;
  logic                  empty, full, do_pop, do_wr, header;
  logic [DATA_WIDTH-1:0] head;
  assign empty  = count == '0;
  assign full   = count == CW'(DEPTH);
  assign do_pop = bus.ib_read_i & ~empty;
  assign do_wr  = bus.ib_valid_i & (~full | do_pop);
  assign head   = mem[rd_ptr];
  assign header = (pkt_cnt == '0) & ~empty;
  assign bus.ib_flit_o        = head;
  assign bus.ib_empty_o       = empty;
  assign bus.ib_header_o      = header;
  assign bus.ib_addr_header_o = header ? head[15:0] : addr_q;
  assign bus.ib_credit_o      = credit;
  assign bus.ib_count_o       = count;
  assign bus.ib_overflow_o    = overflow;
  assign bus.ib_underflow_o   = underflow;
  // storage array; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= bus.ib_flit_i;
  end
  // pointers, occupancy, framing, header address, credit and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_cnt   <= '0;
      addr_q    <= '0;
      credit    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count     <= count + CW'(do_wr) - CW'(do_pop);
      if (do_pop) pkt_cnt <= (pkt_cnt == PW'(PKT_LEN - 1)) ? '0 : pkt_cnt + PW'(1);
      if (do_pop && header) addr_q <= head[15:0];
      credit    <= do_pop;
      overflow  <= overflow | (bus.ib_valid_i & full & ~do_pop);
      underflow <= underflow | (bus.ib_read_i & empty);
    end
  end
endmodule

// File: tb/tb_noc_input_buffer.sv
// tb_noc_input_buffer: table-driven and directed checks of the router input buffer
module tb_noc_input_buffer;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  noc_input_buffer_if #(.DATA_WIDTH(32), .DEPTH(4)) bus ();
  noc_input_buffer #(.DATA_WIDTH(32), .DEPTH(4), .PKT_LEN(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        v;
    logic        r;
    logic [31:0] f;
    logic        e_empty;
    logic        e_hdr;
    logic        e_cred;
    logic [15:0] e_addr;
    logic [2:0]  e_cnt;
    logic        chk_flit;
    logic [31:0] e_flit;
  } vec_t;
  vec_t vecs [10];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask
  task automatic step(input logic v, input logic r, input logic [31:0] f);
    bus.ib_valid_i = v;
    bus.ib_read_i  = r;
    bus.ib_flit_i  = f;
    @(posedge clk);
    #1;
    bus.ib_valid_i = 1'b0;
    bus.ib_read_i  = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
  endtask
  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'hA0000012, 1'b0, 1'b1, 1'b0, 16'h0012, 3'd1, 1'b1, 32'hA0000012};
    vecs[1] = '{1'b1, 1'b0, 32'hB0000001, 1'b0, 1'b1, 1'b0, 16'h0012, 3'd2, 1'b1, 32'hA0000012};
    vecs[2] = '{1'b1, 1'b0, 32'hB0000002, 1'b0, 1'b1, 1'b0, 16'h0012, 3'd3, 1'b1, 32'hA0000012};
    vecs[3] = '{1'b1, 1'b0, 32'hB0000003, 1'b0, 1'b1, 1'b0, 16'h0012, 3'd4, 1'b1, 32'hA0000012};
    vecs[4] = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 16'h0012, 3'd3, 1'b1, 32'hB0000001};
    vecs[5] = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 16'h0012, 3'd2, 1'b1, 32'hB0000002};
    vecs[6] = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 16'h0012, 3'd1, 1'b1, 32'hB0000003};
    vecs[7] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 16'h0012, 3'd0, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'h0012, 3'd0, 1'b0, 32'h0};
    vecs[9] = '{1'b1, 1'b0, 32'hC0000034, 1'b0, 1'b1, 1'b0, 16'h0034, 3'd1, 1'b1, 32'hC0000034};
    bus.ib_valid_i = 1'b0;
    bus.ib_read_i  = 1'b0;
    bus.ib_flit_i  = '0;
    do_reset();
    chk("reset_empty", 32'(bus.ib_empty_o), 32'd1);
    chk("reset_count", 32'(bus.ib_count_o), 32'd0);
    chk("reset_credit", 32'(bus.ib_credit_o), 32'd0);
    chk("reset_header", 32'(bus.ib_header_o), 32'd0);
    chk("reset_addr", 32'(bus.ib_addr_header_o), 32'd0);
    chk("reset_flags", {30'd0, bus.ib_overflow_o, bus.ib_underflow_o}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].v, vecs[i].r, vecs[i].f);
      chk($sformatf("vec%0d_empty", i), 32'(bus.ib_empty_o), 32'(vecs[i].e_empty));
      chk($sformatf("vec%0d_header", i), 32'(bus.ib_header_o), 32'(vecs[i].e_hdr));
      chk($sformatf("vec%0d_credit", i), 32'(bus.ib_credit_o), 32'(vecs[i].e_cred));
      chk($sformatf("vec%0d_addr", i), 32'(bus.ib_addr_header_o), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d_count", i), 32'(bus.ib_count_o), 32'(vecs[i].e_cnt));
      if (vecs[i].chk_flit) chk($sformatf("vec%0d_flit", i), bus.ib_flit_o, vecs[i].e_flit);
    end
    // overflow: fifth write dropped, flag sticky, original four drain in order
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 32'(i));
    step(1'b1, 1'b0, 32'd5);
    chk("ovf_count", 32'(bus.ib_count_o), 32'd4);
    chk("ovf_flag", 32'(bus.ib_overflow_o), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
    chk("ovf_sticky", 32'(bus.ib_overflow_o), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovf_head%0d", i), bus.ib_flit_o, 32'(i));
      step(1'b0, 1'b1, 32'h0);
    end
    chk("ovf_drained", 32'(bus.ib_empty_o), 32'd1);
    // simultaneous write and pop while full
    do_reset();
    for (int i = 10; i <= 13; i++) step(1'b1, 1'b0, 32'(i));
    step(1'b1, 1'b1, 32'd14);
    chk("wr_rd_full_count", 32'(bus.ib_count_o), 32'd4);
    chk("wr_rd_full_ovf", 32'(bus.ib_overflow_o), 32'd0);
    chk("wr_rd_full_credit", 32'(bus.ib_credit_o), 32'd1);
    chk("wr_rd_full_head", bus.ib_flit_o, 32'd11);
    step(1'b0, 1'b0, 32'h0);
    chk("wr_rd_full_credit_end", 32'(bus.ib_credit_o), 32'd0);
    for (int i = 12; i <= 14; i++) begin
      step(1'b0, 1'b1, 32'h0);
      chk($sformatf("wr_rd_full_head%0d", i), bus.ib_flit_o, 32'(i));
    end
    // simultaneous write and read while empty: write only, underflow flagged
    do_reset();
    step(1'b1, 1'b1, 32'h55);
    chk("wr_rd_empty_count", 32'(bus.ib_count_o), 32'd1);
    chk("wr_rd_empty_unf", 32'(bus.ib_underflow_o), 32'd1);
    chk("wr_rd_empty_credit", 32'(bus.ib_credit_o), 32'd0);
    chk("wr_rd_empty_head", bus.ib_flit_o, 32'h55);
    step(1'b0, 1'b0, 32'h0);
    chk("wr_rd_empty_credit2", 32'(bus.ib_credit_o), 32'd0);
    // reset mid-operation with flits stored, credit pending and flags set
    do_reset();
    step(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h100 + 32'(i));
    step(1'b0, 1'b1, 32'h0);
    chk("pre_rst_count", 32'(bus.ib_count_o), 32'd3);
    chk("pre_rst_credit", 32'(bus.ib_credit_o), 32'd1);
    chk("pre_rst_flags", {30'd0, bus.ib_overflow_o, bus.ib_underflow_o}, 32'd3);
    do_reset();
    chk("rst_count", 32'(bus.ib_count_o), 32'd0);
    chk("rst_empty", 32'(bus.ib_empty_o), 32'd1);
    chk("rst_credit", 32'(bus.ib_credit_o), 32'd0);
    chk("rst_flags", {30'd0, bus.ib_overflow_o, bus.ib_underflow_o}, 32'd0);
    chk("rst_header", 32'(bus.ib_header_o), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
